// File: rtl/arb_pkg.sv
// arb_pkg: shared state type, requester count and one-hot helper for the arbiter
package arb_pkg;
  localparam int N_REQ = 4;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic logic [N_REQ-1:0] onehot(input logic [$clog2(N_REQ)-1:0] i);
    return N_REQ'(1) << i;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority pick, first asserted request at or after ptr
module rr_pick import arb_pkg::*; #(
  parameter int N = N_REQ,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win_onehot,
  output logic [PW-1:0] win_idx,
  output logic          any
);
  logic [N-1:0] rot, sel;
  always_comb begin
    rot = '0;
    win_onehot = '0;
    win_idx = '0;
    for (int k = 0; k < N; k++) rot[k] = req[(k + int'(ptr)) % N];
    sel = rot & (~rot + N'(1));
    for (int k = 0; k < N; k++) win_onehot[(k + int'(ptr)) % N] = sel[k];
    for (int k = 0; k < N; k++) if (win_onehot[k]) win_idx = PW'(k);
  end
  assign any = |req;
endmodule

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: round-robin arbiter with held one-hot grant, release handshake
// and a watchdog that revokes grants held for TIMEOUT cycles
module rr_arbiter4 import arb_pkg::*; #(
  parameter int N = N_REQ,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] gnt,
  output logic         busy,
  output logic         timeout
);
  localparam int PW = $clog2(N);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  state_t state, state_nxt;
  logic [PW-1:0] ptr, idx, win_idx;
  logic [N-1:0] win;
  logic [CW-1:0] cnt;
  logic any, wd, rel;
  rr_pick #(.N(N)) u_pick (.req(req), .ptr(ptr), .win_onehot(win), .win_idx(win_idx), .any(any));
  assign wd = TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);
  assign rel = state == GRANT && (done || !req[idx] || wd);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (any ? GRANT : IDLE) : (rel ? IDLE : GRANT);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt <= '0;
      ptr <= '0;
      idx <= '0;
      cnt <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (state == IDLE) begin
        gnt <= win;
        idx <= win_idx;
        cnt <= '0;
      end else if (rel) begin
        gnt <= '0;
        ptr <= idx == PW'(N - 1) ? '0 : idx + PW'(1);
        timeout <= wd;
      end else begin
        cnt <= cnt == CW'(TIMEOUT) ? cnt : cnt + CW'(1);
      end
    end
  end
  assign busy = |gnt;
endmodule
